// File: rtl/reel_stop_sequencer.sv
// Slot round sequencer: releases the three reels on START, stops them in order reel3, reel2, reel1
// on registered stop-button edges or on timeout, then scores the frozen digits.
module reel_stop_sequencer #(
    parameter int MIN_SPIN   = 25_000_000,
    parameter int TIMEOUT    = 250_000_000,
    parameter int SETTLE     = 4,
    parameter int PAY_TRIPLE = 10,
    parameter int PAY_PAIR   = 5,
    parameter int PAY_NONE   = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic       SBTN1,
    input  logic       SBTN2,
    input  logic       SBTN3,
    input  logic [3:0] REEL1,
    input  logic [3:0] REEL2,
    input  logic [3:0] REEL3,
    output logic       STOP1,
    output logic       STOP2,
    output logic       STOP3,
    output logic       LED_IN,
    output logic       BUSY,
    output logic       DONE,
    output logic [1:0] MATCH,
    output logic [3:0] PAYOUT
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] MIN_C    = CW'(MIN_SPIN);
    localparam logic [CW-1:0] LAST_C   = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] SETTLE_C = CW'(SETTLE);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SPIN3  = 3'd1;
    localparam logic [2:0] S_SPIN2  = 3'd2;
    localparam logic [2:0] S_SPIN1  = 3'd3;
    localparam logic [2:0] S_EVAL   = 3'd4;
    localparam logic [2:0] S_REPORT = 3'd5;

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    btn_q;
    logic [2:0]    btn_edge;
    logic          owned_edge;
    logic          stop_now;
    logic          eq12, eq13, eq23;
    logic [1:0]    match_nxt;
    logic [3:0]    pay_nxt;

    // Only the button belonging to the reel currently spinning may stop it.
    always_comb begin
        owned_edge = 1'b0;
        case (state)
            S_SPIN3: owned_edge = btn_edge[0];
            S_SPIN2: owned_edge = btn_edge[1];
            S_SPIN1: owned_edge = btn_edge[2];
            default: owned_edge = 1'b0;
        endcase
        stop_now = (owned_edge && (cnt >= MIN_C)) || (cnt == LAST_C);
    end

    always_comb begin
        eq12 = (REEL1 == REEL2);
        eq13 = (REEL1 == REEL3);
        eq23 = (REEL2 == REEL3);
        if (eq12 && eq13 && eq23) begin
            match_nxt = 2'd2;
            pay_nxt   = 4'(PAY_TRIPLE);
        end else if (eq12 || eq13 || eq23) begin
            match_nxt = 2'd1;
            pay_nxt   = 4'(PAY_PAIR);
        end else begin
            match_nxt = 2'd0;
            pay_nxt   = 4'(PAY_NONE);
        end
    end

    assign BUSY = (state != S_IDLE);

    // The spin counter doubles as the settle timer in EVAL; it is cleared at every stop.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= S_IDLE;
            cnt      <= '0;
            btn_q    <= '0;
            btn_edge <= '0;
            STOP1    <= 1'b1;
            STOP2    <= 1'b1;
            STOP3    <= 1'b1;
            LED_IN   <= 1'b0;
            DONE     <= 1'b0;
            MATCH    <= 2'd0;
            PAYOUT   <= 4'd0;
        end else begin
            btn_q    <= {SBTN3, SBTN2, SBTN1};
            btn_edge <= {SBTN3, SBTN2, SBTN1} & ~btn_q;
            DONE     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (START) begin
                        state  <= S_SPIN3;
                        STOP1  <= 1'b0;
                        STOP2  <= 1'b0;
                        STOP3  <= 1'b0;
                        LED_IN <= 1'b1;
                        cnt    <= '0;
                    end
                end
                S_SPIN3: begin
                    if (stop_now) begin
                        STOP3 <= 1'b1;
                        cnt   <= '0;
                        state <= S_SPIN2;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_SPIN2: begin
                    if (stop_now) begin
                        STOP2 <= 1'b1;
                        cnt   <= '0;
                        state <= S_SPIN1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_SPIN1: begin
                    if (stop_now) begin
                        STOP1  <= 1'b1;
                        LED_IN <= 1'b0;
                        cnt    <= '0;
                        state  <= S_EVAL;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_EVAL: begin
                    if (cnt == SETTLE_C) begin
                        MATCH  <= match_nxt;
                        PAYOUT <= pay_nxt;
                        DONE   <= 1'b1;
                        cnt    <= '0;
                        state  <= S_REPORT;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_REPORT: state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reel_stop_sequencer.sv
// Directed bench for reel_stop_sequencer with short timing (MIN_SPIN=4, TIMEOUT=20, SETTLE=2).
module tb_reel_stop_sequencer;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       START = 1'b0;
    logic       SBTN1 = 1'b0;
    logic       SBTN2 = 1'b0;
    logic       SBTN3 = 1'b0;
    logic [3:0] REEL1 = 4'd0;
    logic [3:0] REEL2 = 4'd0;
    logic [3:0] REEL3 = 4'd0;
    logic       STOP1, STOP2, STOP3, LED_IN, BUSY, DONE;
    logic [1:0] MATCH;
    logic [3:0] PAYOUT;

    int errors = 0;
    int checks = 0;
    int doneSeen;

    reel_stop_sequencer #(
        .MIN_SPIN(4), .TIMEOUT(20), .SETTLE(2),
        .PAY_TRIPLE(10), .PAY_PAIR(5), .PAY_NONE(1)
    ) dut (
        .CLK(CLK), .RST(RST), .START(START),
        .SBTN1(SBTN1), .SBTN2(SBTN2), .SBTN3(SBTN3),
        .REEL1(REEL1), .REEL2(REEL2), .REEL3(REEL3),
        .STOP1(STOP1), .STOP2(STOP2), .STOP3(STOP3),
        .LED_IN(LED_IN), .BUSY(BUSY), .DONE(DONE),
        .MATCH(MATCH), .PAYOUT(PAYOUT)
    );

    always #5 CLK = ~CLK;

    // Inputs change and outputs are sampled 1ns after each rising edge.
    task automatic stepCycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int n, input logic level);
        case (n)
            1: SBTN1 = level;
            2: SBTN2 = level;
            default: SBTN3 = level;
        endcase
    endtask

    task automatic pressButton(input int n);
        applyStimulus(n, 1'b1);
        stepCycle();
        applyStimulus(n, 1'b0);
        stepCycle();
    endtask

    task automatic runRound(input logic [3:0] r1, input logic [3:0] r2, input logic [3:0] r3,
                            input int expMatch, input int expPay);
        START = 1'b1;
        stepCycle();
        START = 1'b0;
        checkOutput("round_stops_low", {STOP1, STOP2, STOP3}, 0);
        for (int n = 1; n <= 3; n++) begin
            repeat (4) stepCycle();
            pressButton(n);
        end
        checkOutput("round_all_stopped", {STOP1, STOP2, STOP3}, 7);
        REEL1 = r1;
        REEL2 = r2;
        REEL3 = r3;
        repeat (2) stepCycle();
        checkOutput("round_done_early", DONE, 0);
        stepCycle();
        checkOutput("round_done", DONE, 1);
        checkOutput("round_match", MATCH, expMatch);
        checkOutput("round_payout", PAYOUT, expPay);
        stepCycle();
        checkOutput("round_done_single", DONE, 0);
        checkOutput("round_idle", BUSY, 0);
    endtask

    initial begin
        $display("[TB] reel_stop_sequencer directed test");
        repeat (2) stepCycle();
        RST = 1'b0;
        checkOutput("reset_stops", {STOP1, STOP2, STOP3}, 7);
        checkOutput("reset_busy", BUSY, 0);
        checkOutput("reset_led", LED_IN, 0);
        checkOutput("reset_done", DONE, 0);
        checkOutput("reset_match", MATCH, 0);
        checkOutput("reset_payout", PAYOUT, 0);
        doneSeen = 0;
        for (int i = 0; i < 10; i++) begin
            stepCycle();
            if (DONE === 1'b1 || BUSY !== 1'b0) doneSeen++;
        end
        checkOutput("idle_quiet", doneSeen, 0);

        // Early edge rejected, later fresh edge accepted; foreign button ignored.
        START = 1'b1;
        stepCycle();
        START = 1'b0;
        checkOutput("start_stops_low", {STOP1, STOP2, STOP3}, 0);
        checkOutput("start_led", LED_IN, 1);
        checkOutput("start_busy", BUSY, 1);
        stepCycle();
        SBTN1 = 1'b1;
        stepCycle();
        SBTN1 = 1'b0;
        stepCycle();
        checkOutput("early_edge_ignored", STOP3, 0);
        repeat (2) stepCycle();
        SBTN1 = 1'b1;
        stepCycle();
        checkOutput("stop3_latency", STOP3, 0);
        SBTN1 = 1'b0;
        stepCycle();
        checkOutput("stop3_after_edge", STOP3, 1);
        checkOutput("stop2_still_spin", STOP2, 0);
        repeat (4) stepCycle();
        pressButton(1);
        checkOutput("foreign_button_ignored", STOP2, 0);
        pressButton(2);
        checkOutput("stop2_after_edge", {STOP1, STOP2}, 1);
        repeat (4) stepCycle();
        pressButton(3);
        checkOutput("stop1_after_edge", STOP1, 1);
        checkOutput("led_off_at_stop1", LED_IN, 0);
        REEL1 = 4'd7;
        REEL2 = 4'd7;
        REEL3 = 4'd7;
        repeat (2) stepCycle();
        checkOutput("settle_no_done", DONE, 0);
        stepCycle();
        checkOutput("triple_done", DONE, 1);
        checkOutput("triple_match", MATCH, 2);
        checkOutput("triple_payout", PAYOUT, 10);
        START = 1'b1;
        stepCycle();
        START = 1'b0;
        checkOutput("report_start_ignored", BUSY, 0);
        checkOutput("report_start_stops", {STOP1, STOP2, STOP3}, 7);
        REEL2 = 4'd1;
        repeat (2) stepCycle();
        checkOutput("match_held", MATCH, 2);
        checkOutput("payout_held", PAYOUT, 10);

        runRound(4'd3, 4'd5, 4'd3, 1, 5);
        runRound(4'd1, 4'd2, 4'd3, 0, 1);
        runRound(4'd6, 4'd6, 4'd2, 1, 5);

        // No buttons: each reel times out 20 cycles after the previous one.
        START = 1'b1;
        stepCycle();
        START = 1'b0;
        REEL1 = 4'd2;
        REEL2 = 4'd8;
        REEL3 = 4'd2;
        repeat (19) stepCycle();
        checkOutput("timeout3_before", STOP3, 0);
        stepCycle();
        checkOutput("timeout3_stop", STOP3, 1);
        repeat (19) stepCycle();
        checkOutput("timeout2_before", STOP2, 0);
        stepCycle();
        checkOutput("timeout2_stop", STOP2, 1);
        repeat (19) stepCycle();
        checkOutput("timeout1_before", {STOP1, LED_IN}, 1);
        stepCycle();
        checkOutput("timeout1_stop", {STOP1, LED_IN}, 2);
        repeat (2) stepCycle();
        checkOutput("timeout_no_done_yet", DONE, 0);
        stepCycle();
        checkOutput("timeout_done", DONE, 1);
        checkOutput("timeout_match", MATCH, 1);
        stepCycle();

        // Reset while reel2 spins.
        START = 1'b1;
        stepCycle();
        START = 1'b0;
        repeat (4) stepCycle();
        pressButton(1);
        checkOutput("pre_reset_spin2", {STOP2, STOP3}, 1);
        repeat (2) stepCycle();
        RST = 1'b1;
        stepCycle();
        RST = 1'b0;
        checkOutput("midreset_stops", {STOP1, STOP2, STOP3}, 7);
        checkOutput("midreset_busy", BUSY, 0);
        checkOutput("midreset_led", LED_IN, 0);
        checkOutput("midreset_match", MATCH, 0);
        doneSeen = 0;
        for (int i = 0; i < 8; i++) begin
            stepCycle();
            if (DONE === 1'b1) doneSeen++;
        end
        checkOutput("midreset_no_done", doneSeen, 0);

        // SBTN2 held across MIN_SPIN: reel2 only stops on timeout.
        START = 1'b1;
        stepCycle();
        START = 1'b0;
        repeat (4) stepCycle();
        pressButton(1);
        stepCycle();
        SBTN2 = 1'b1;
        repeat (18) stepCycle();
        checkOutput("held_no_stop", STOP2, 0);
        stepCycle();
        checkOutput("held_timeout_stop", STOP2, 1);
        SBTN2 = 1'b0;
        REEL1 = 4'd4;
        REEL2 = 4'd9;
        REEL3 = 4'd9;
        repeat (4) stepCycle();
        pressButton(3);
        repeat (3) stepCycle();
        checkOutput("held_done", DONE, 1);
        checkOutput("held_match", MATCH, 1);
        checkOutput("held_payout", PAYOUT, 5);
        stepCycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
